// File: rtl/kd_node_loader.sv
`default_nettype none
// ============================================================================
// kd_node_loader : turns an (index, median) word stream into one-hot
//                  internal_node writes, breadth-first from the root.
// Optional macro  : KD_NODE_LOADER_IDX_CHECK_EN (split-index range check)
// Revision        : 1.0
// ============================================================================
module kd_node_loader #(
    parameter int COMP_WIDTH    = 11,
    parameter int STORAGE_WIDTH = 22,
    parameter int NUM_DIMS      = 5,
    parameter int NUM_NODES     = 31,
    parameter int CNT_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [COMP_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic [NUM_NODES-1:0]     wen,
    output logic [STORAGE_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0]     node_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_IDX = 3'd1,
        S_GET_MED = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_NODES - 1);

    state_t                  state;
    logic [COMP_WIDTH-1:0]   idx_reg;
    logic                    idx_ok;

`ifdef KD_NODE_LOADER_IDX_CHECK_EN
    localparam logic [COMP_WIDTH-1:0] DIMS_C = COMP_WIDTH'(NUM_DIMS);
    assign idx_ok = (idx_reg < DIMS_C);
`else
    assign idx_ok = 1'b1;
`endif

    // wen and wdata are launched on the median transfer so they are
    // registered and valid during the WRITE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wen      <= '0;
            wdata    <= '0;
            node_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx_reg  <= '0;
        end else begin
            wen <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_GET_IDX;
                        node_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                S_GET_IDX: begin
                    if (in_valid && in_ready) begin
                        idx_reg <= in_data;
                        state   <= S_GET_MED;
                    end
                end
                S_GET_MED: begin
                    if (in_valid && in_ready) begin
                        wdata    <= {in_data, idx_reg};
                        if (idx_ok) begin
                            wen <= NUM_NODES'(1) << node_cnt;
                        end
                        in_ready <= 1'b0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!idx_ok) begin
                        err <= 1'b1;
                    end
                    if (node_cnt == LAST_CNT) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        node_cnt <= node_cnt + 1'b1;
                        in_ready <= 1'b1;
                        state    <= S_GET_IDX;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kd_node_loader.sv
`default_nettype none
// ============================================================================
// tb_kd_node_loader : randomized stream stimulus against a node-table model.
// Revision          : 1.0
// ============================================================================
module tb_kd_node_loader;

    localparam int CW   = 11;
    localparam int SW   = 22;
    localparam int ND   = 5;
    localparam int NN   = 31;
    localparam int CNTW = 5;
`ifdef KD_NODE_LOADER_IDX_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start = 1'b0, in_valid = 1'b0;
    logic [CW-1:0]   in_data = '0;
    logic            in_ready, busy, done, err;
    logic [NN-1:0]   wen;
    logic [SW-1:0]   wdata;
    logic [CNTW-1:0] node_cnt;

    logic            s_start = 1'b0, s_valid = 1'b0;
    logic [CW-1:0]   s_data = '0;
    logic            s_ready, s_busy, s_done, s_err;
    logic [0:0]      s_wen, s_cnt;
    logic [SW-1:0]   s_wdata;

    kd_node_loader #(.COMP_WIDTH(CW), .STORAGE_WIDTH(SW), .NUM_DIMS(ND),
                     .NUM_NODES(NN), .CNT_WIDTH(CNTW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wen(wen), .wdata(wdata),
        .node_cnt(node_cnt), .busy(busy), .done(done), .err(err));

    kd_node_loader #(.COMP_WIDTH(CW), .STORAGE_WIDTH(SW), .NUM_DIMS(ND),
                     .NUM_NODES(1), .CNT_WIDTH(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
        .in_data(s_data), .in_ready(s_ready), .wen(s_wen), .wdata(s_wdata),
        .node_cnt(s_cnt), .busy(s_busy), .done(s_done), .err(s_err));

    int checks = 0;
    int errors = 0;

    // Reference node table: what each node should be programmed with.
    logic [CW-1:0] q_idx [NN];
    logic [CW-1:0] q_med [NN];

    function automatic bit suppressed(input int i);
        return CHECK_EN && (q_idx[i] >= CW'(ND));
    endfunction

    function automatic logic [CW-1:0] word_at(input int w);
        return (w % 2 == 0) ? q_idx[w/2] : q_med[w/2];
    endfunction

    task automatic fill(input bit wide_idx);
        for (int i = 0; i < NN; i++) begin
            q_idx[i] = wide_idx ? CW'($urandom_range(0, (1 << CW) - 1))
                                : CW'($urandom_range(0, ND - 1));
            q_med[i] = CW'($urandom_range(0, (1 << CW) - 1));
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Streams words [first..2*NN) with random stalls and checks every write.
    task automatic run_load(input int first, input int stall_pct, input bit strict);
        int  ptr, got, exp_n, mon_last, done_cyc;
        bit  any_err;
        ptr = 0; got = 0; exp_n = 0; mon_last = -1; done_cyc = -1; any_err = 1'b0;
        fork
            begin : drv
                int w;
                int g;
                w = first;
                g = 0;
                while (w < 2 * NN && g < 5000) begin
                    @(negedge clk);
                    g++;
                    if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'b1;
                        in_data  = word_at(w);
                        if (in_ready) w++;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : mon
                int cyc;
                cyc = 0;
                while (done_cyc < 0 && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if ($countones(wen) > 1) begin
                        errors++;
                        $display("FAIL onehot: wen=%h has %0d bits set", wen, $countones(wen));
                    end
                    if (wen != '0) begin
                        while (ptr < NN && suppressed(ptr)) ptr++;
                        checks++;
                        if (ptr >= NN) begin
                            errors++;
                            $display("FAIL extra_write: wen=%h, no write expected", wen);
                        end else if (wen !== (NN'(1) << ptr) || wdata !== {q_med[ptr], q_idx[ptr]}
                                     || node_cnt !== CNTW'(ptr)) begin
                            errors++;
                            $display("FAIL write: wen=%h wdata=%h cnt=%0d, expected wen=%h wdata=%h cnt=%0d",
                                     wen, wdata, node_cnt, NN'(1) << ptr, {q_med[ptr], q_idx[ptr]}, ptr);
                        end
                        if (strict && mon_last >= 0) begin
                            checks++;
                            if (cyc - mon_last != 3) begin
                                errors++;
                                $display("FAIL spacing: %0d cycles between writes, expected 3", cyc - mon_last);
                            end
                        end
                        mon_last = cyc;
                        ptr++;
                        got++;
                    end
                    if (done) done_cyc = cyc;
                end
            end
        join
        for (int i = 0; i < NN; i++) begin
            if (!suppressed(i)) exp_n++;
            else any_err = 1'b1;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: done never rose, got %0d writes", got);
        end
        checks++;
        if (got != exp_n) begin
            errors++;
            $display("FAIL write_count: %0d writes, expected %0d", got, exp_n);
        end
        if (strict) begin
            checks++;
            if (done_cyc - mon_last != 1) begin
                errors++;
                $display("FAIL done_latency: done %0d cycles after last wen, expected 1", done_cyc - mon_last);
            end
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || err !== any_err
            || wdata !== {q_med[NN-1], q_idx[NN-1]}) begin
            errors++;
            $display("FAIL end_state: busy=%b ready=%b err=%b wdata=%h, expected 0 0 %b %h",
                     busy, in_ready, err, wdata, any_err, {q_med[NN-1], q_idx[NN-1]});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wen !== '0 || wdata !== '0 || in_ready !== 1'b0 || busy !== 1'b0
            || done !== 1'b0 || err !== 1'b0 || node_cnt !== '0) begin
            errors++;
            $display("FAIL reset: wen=%h wdata=%h rdy=%b busy=%b done=%b err=%b cnt=%0d, expected all 0",
                     wen, wdata, in_ready, busy, done, err, node_cnt);
        end
        checks++;
        if (s_wen !== 1'b0 || s_wdata !== '0 || s_ready !== 1'b0 || s_busy !== 1'b0
            || s_done !== 1'b0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_one: wen=%b wdata=%h rdy=%b busy=%b done=%b, expected all 0",
                     s_wen, s_wdata, s_ready, s_busy, s_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_node();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0; s_valid = 1'b1; s_data = CW'(1);
        @(negedge clk); s_data = CW'(2);
        @(negedge clk); s_valid = 1'b0;
        checks++;
        if (s_wen !== 1'b1 || s_wdata !== 22'h1001) begin
            errors++;
            $display("FAIL single_write: wen=%b wdata=%h, expected 1 001001", s_wen, s_wdata);
        end
        @(negedge clk);
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_ready !== 1'b0 || s_wen !== 1'b0
            || s_wdata !== 22'h1001) begin
            errors++;
            $display("FAIL single_done: done=%b busy=%b rdy=%b wen=%b wdata=%h, expected 1 0 0 0 001001",
                     s_done, s_busy, s_ready, s_wen, s_wdata);
        end
    endtask

    task automatic test_full_load();
        fill(1'b0);
        do_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1 || node_cnt !== '0) begin
            errors++;
            $display("FAIL start_state: busy=%b done=%b rdy=%b cnt=%0d, expected 1 0 1 0",
                     busy, done, in_ready, node_cnt);
        end
        run_load(0, 0, 1'b1);
    endtask

    task automatic test_stall();
        logic [SW-1:0] prev;
        fill(1'b1);
        do_start();
        in_valid = 1'b1;
        in_data  = q_idx[0];
        @(negedge clk);
        in_valid = 1'b0;
        prev = wdata;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready !== 1'b1 || wen !== '0 || wdata !== prev) begin
                errors++;
                $display("FAIL stall: rdy=%b wen=%h wdata=%h, expected 1 0 %h", in_ready, wen, wdata, prev);
            end
            @(negedge clk);
        end
        run_load(1, 30, 1'b0);
    endtask

    task automatic test_idx_error();
        fill(1'b0);
        q_idx[2] = CW'(7);
        do_start();
        run_load(0, 20, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== CHECK_EN || done !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b done=%b, expected %b 1", err, done, CHECK_EN);
        end
    endtask

    task automatic test_back_to_back();
        fill(1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || node_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b err=%b cnt=%0d rdy=%b, expected 1 0 0 0 1",
                     busy, done, err, node_cnt, in_ready);
        end
        run_load(0, 0, 1'b1);
    endtask

    task automatic test_abort();
        int w;
        int g;
        bit seen3;
        fill(1'b0);
        do_start();
        w = 0; g = 0; seen3 = 1'b0;
        while (w < 7 && g < 200) begin
            @(negedge clk);
            g++;
            if (wen[3]) seen3 = 1'b1;
            in_valid = 1'b1;
            in_data  = word_at(w);
            if (in_ready) w++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wen !== '0 || wdata !== '0 || in_ready !== 1'b0 || busy !== 1'b0
            || done !== 1'b0 || err !== 1'b0 || node_cnt !== '0) begin
            errors++;
            $display("FAIL abort_reset: wen=%h wdata=%h rdy=%b busy=%b cnt=%0d, expected all 0",
                     wen, wdata, in_ready, busy, node_cnt);
        end
        @(negedge clk);
        if (wen[3]) seen3 = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (seen3 || g >= 200) begin
            errors++;
            $display("FAIL abort_wen3: wen3_seen=%b loop=%0d, expected 0 and <200", seen3, g);
        end
        fill(1'b0);
        do_start();
        run_load(0, 10, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_node();
        test_full_load();
        test_stall();
        test_idx_error();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
